// File: rtl/shifter_pkg.sv
// Shared command definitions for the doubler/shifter datapath and its benches.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shifter_pkg;

    localparam int DATA_W = 4;
    localparam int CTRL_W = 3;

    // Control code driven to the shifter when no command is being issued.
    localparam logic [CTRL_W-1:0] CTRL_IDLE = 3'b000;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
    } cmd_t;

    function automatic cmd_t make_cmd(input logic [DATA_W-1:0] data,
                                      input logic [CTRL_W-1:0] ctrl);
        cmd_t c;
        c.data = data;
        c.ctrl = ctrl;
        return c;
    endfunction

endpackage

// File: rtl/shifter_cmd_queue_sync_fifo.sv
// Synchronous FIFO with clear: storage, wrapping pointers and occupancy level.
// Latency: a written entry is visible at rdata the cycle after the write edge.
// Backpressure: pushes when full and pops when empty are ignored; clear wins over both.
module sync_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign push_ok = push & ~full & ~clear;
    assign pop_ok  = pop & ~empty & ~clear;
    assign rdata   = mem_q[rd_ptr_q];
    assign level   = level_q;

    // Next pointers and level; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + LW'(push_ok) - LW'(pop_ok);
        end
    end

    // Pointer and level state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage write; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/shifter_cmd_queue.sv
// Command queue feeding the shifter: buffers (data, ctrl) and issues one per clock, idle code when empty.
// Latency: a command pushed at edge N reaches out_* after edge N+1 when at the head and not stalled.
// Backpressure: in_ready = level < DEPTH (no same-cycle pop look-ahead); stall freezes issue, flush drops all.
module shifter_cmd_queue #(
    parameter int DATA_W = shifter_pkg::DATA_W,
    parameter int CTRL_W = shifter_pkg::CTRL_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic                   stall,
    input  logic                   flush,
    output logic [DATA_W-1:0]      out_data,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic                   out_valid,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_W-1:0]       issue_cnt
);

    import shifter_pkg::*;

    localparam int W = DATA_W + CTRL_W;
    localparam logic [CTRL_W-1:0] IDLE_CODE = CTRL_W'(CTRL_IDLE);

    logic [W-1:0]      head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
    logic              out_valid_q, out_valid_d;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;

    assign in_ready = ~fifo_full;
    assign push     = in_valid & in_ready & ~flush;
    assign pop      = ~stall & ~flush & ~fifo_empty;

    sync_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (push),
        .wdata ({in_data, in_ctrl}),
        .pop   (pop),
        .rdata (head),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Issue-register next state: flush idles, stall holds, otherwise pop head or idle.
    always_comb begin
        out_data_d  = out_data_q;
        out_ctrl_d  = out_ctrl_q;
        out_valid_d = out_valid_q;
        issue_cnt_d = issue_cnt_q;
        if (flush) begin
            out_data_d  = '0;
            out_ctrl_d  = IDLE_CODE;
            out_valid_d = 1'b0;
        end else if (!stall) begin
            if (pop) begin
                out_data_d  = head[W-1:CTRL_W];
                out_ctrl_d  = head[CTRL_W-1:0];
                out_valid_d = 1'b1;
                issue_cnt_d = issue_cnt_q + CNT_W'(1);
            end else begin
                out_data_d  = '0;
                out_ctrl_d  = IDLE_CODE;
                out_valid_d = 1'b0;
            end
        end
    end

    // Issue registers and running issue count.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_ctrl_q  <= IDLE_CODE;
            out_valid_q <= 1'b0;
            issue_cnt_q <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ctrl_q  <= out_ctrl_d;
            out_valid_q <= out_valid_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ctrl  = out_ctrl_q;
    assign out_valid = out_valid_q;
    assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_shifter_cmd_queue.sv
// Bench for shifter_cmd_queue: fixed vector table, hand sequences, then random traffic vs a queue model.
module tb_shifter_cmd_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [2:0] in_ctrl;
    logic       stall;
    logic       flush;
    logic [3:0] out_data;
    logic [2:0] out_ctrl;
    logic       out_valid;
    logic [2:0] level;
    logic [7:0] issue_cnt;

    // Second instance with a 2-bit counter sharing all inputs, for wrap checks.
    logic       in_ready2;
    logic [3:0] out_data2;
    logic [2:0] out_ctrl2;
    logic       out_valid2;
    logic [2:0] level2;
    logic [1:0] issue_cnt2;

    always #5 clk = ~clk;

    shifter_cmd_queue #(.DATA_W(4), .CTRL_W(3), .DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .stall(stall), .flush(flush),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_valid(out_valid),
        .level(level), .issue_cnt(issue_cnt)
    );

    shifter_cmd_queue #(.DATA_W(4), .CTRL_W(3), .DEPTH(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_ctrl(in_ctrl), .stall(stall), .flush(flush),
        .out_data(out_data2), .out_ctrl(out_ctrl2), .out_valid(out_valid2),
        .level(level2), .issue_cnt(issue_cnt2)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: a plain queue of commands plus the last issued command.
    typedef struct {
        int data;
        int ctrl;
    } mcmd_t;
    mcmd_t m_q[$];
    int    m_data, m_ctrl, m_valid, m_cnt;

    typedef struct {
        int v, d, c, s, f;
        int rdy, od, oc, ov, lvl, cnt;
    } vec_t;
    vec_t tbl[24];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_data  = 0;
        m_ctrl  = 0;
        m_valid = 0;
        m_cnt   = 0;
    endtask

    // Entered and left at a falling edge: drive, advance one rising edge, compare with the model.
    task automatic step(input int v, input int d, input int c, input int s, input int f);
        int    accept;
        mcmd_t cmd;
        in_valid = (v != 0);
        in_data  = d[3:0];
        in_ctrl  = c[2:0];
        stall    = (s != 0);
        flush    = (f != 0);
        #1;
        check("model_in_ready", int'(in_ready), int'(m_q.size() < 4));
        accept = (v != 0) && (m_q.size() < 4) && (f == 0);
        if (f != 0) begin
            m_q.delete();
            m_data = 0; m_ctrl = 0; m_valid = 0;
        end else begin
            if (s == 0) begin
                if (m_q.size() > 0) begin
                    cmd = m_q.pop_front();
                    m_data = cmd.data; m_ctrl = cmd.ctrl; m_valid = 1;
                    m_cnt++;
                end else begin
                    m_data = 0; m_ctrl = 0; m_valid = 0;
                end
            end
            if (accept != 0) begin
                cmd.data = d & 15;
                cmd.ctrl = c & 7;
                m_q.push_back(cmd);
            end
        end
        @(posedge clk);
        @(negedge clk);
        check("model_out_data",  int'(out_data),   m_data);
        check("model_out_ctrl",  int'(out_ctrl),   m_ctrl);
        check("model_out_valid", int'(out_valid),  m_valid);
        check("model_level",     int'(level),      m_q.size());
        check("model_issue_cnt", int'(issue_cnt),  m_cnt % 256);
        check("model_cnt_w2",    int'(issue_cnt2), m_cnt % 4);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_ctrl = '0; stall = 1'b0; flush = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_data",  int'(out_data),  0);
        check("rst_out_ctrl",  int'(out_ctrl),  0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready",  int'(in_ready),  1);
        check("rst_level",     int'(level),     0);
        check("rst_issue_cnt", int'(issue_cnt), 0);
    endtask

    initial begin
        int wrap_exp[5];
        //               v  d   c  s  f   rdy od  oc ov lvl cnt
        tbl[0]  = '{1, 10, 2, 0, 0,  1, 0,  0, 0, 1, 0};
        tbl[1]  = '{0, 0,  0, 0, 0,  1, 10, 2, 1, 0, 1};
        tbl[2]  = '{0, 0,  0, 0, 0,  1, 0,  0, 0, 0, 1};
        tbl[3]  = '{1, 1,  1, 1, 0,  1, 0,  0, 0, 1, 1};
        tbl[4]  = '{1, 2,  3, 1, 0,  1, 0,  0, 0, 2, 1};
        tbl[5]  = '{1, 3,  4, 1, 0,  1, 0,  0, 0, 3, 1};
        tbl[6]  = '{1, 4,  5, 1, 0,  1, 0,  0, 0, 4, 1};
        tbl[7]  = '{1, 5,  6, 1, 0,  0, 0,  0, 0, 4, 1};
        tbl[8]  = '{0, 0,  0, 0, 0,  0, 1,  1, 1, 3, 2};
        tbl[9]  = '{0, 0,  0, 0, 0,  1, 2,  3, 1, 2, 3};
        tbl[10] = '{0, 0,  0, 0, 0,  1, 3,  4, 1, 1, 4};
        tbl[11] = '{0, 0,  0, 0, 0,  1, 4,  5, 1, 0, 5};
        tbl[12] = '{0, 0,  0, 0, 0,  1, 0,  0, 0, 0, 5};
        tbl[13] = '{1, 7,  7, 1, 0,  1, 0,  0, 0, 1, 5};
        tbl[14] = '{1, 8,  0, 1, 0,  1, 0,  0, 0, 2, 5};
        tbl[15] = '{1, 9,  1, 1, 0,  1, 0,  0, 0, 3, 5};
        tbl[16] = '{1, 10, 2, 1, 1,  1, 0,  0, 0, 0, 5};
        tbl[17] = '{0, 0,  0, 0, 0,  1, 0,  0, 0, 0, 5};
        tbl[18] = '{1, 10, 1, 1, 0,  1, 0,  0, 0, 1, 5};
        tbl[19] = '{1, 11, 2, 1, 0,  1, 0,  0, 0, 2, 5};
        tbl[20] = '{1, 12, 3, 0, 0,  1, 10, 1, 1, 2, 6};
        tbl[21] = '{0, 0,  0, 0, 0,  1, 11, 2, 1, 1, 7};
        tbl[22] = '{0, 0,  0, 0, 0,  1, 12, 3, 1, 0, 8};
        tbl[23] = '{0, 0,  0, 0, 0,  1, 0,  0, 0, 0, 8};

        do_reset();

        // Fixed vectors: single push latency, stalled fill to full, flush, push+pop at level 2.
        for (int i = 0; i < 24; i++) begin
            check($sformatf("tbl%0d_in_ready", i), int'(in_ready), tbl[i].rdy);
            step(tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].s, tbl[i].f);
            check($sformatf("tbl%0d_out_data", i),  int'(out_data),  tbl[i].od);
            check($sformatf("tbl%0d_out_ctrl", i),  int'(out_ctrl),  tbl[i].oc);
            check($sformatf("tbl%0d_out_valid", i), int'(out_valid), tbl[i].ov);
            check($sformatf("tbl%0d_level", i),     int'(level),     tbl[i].lvl);
            check($sformatf("tbl%0d_issue_cnt", i), int'(issue_cnt), tbl[i].cnt);
        end

        // Narrow counter wrap: 1,2,3,0,1 across five issues.
        do_reset();
        wrap_exp[0] = 1; wrap_exp[1] = 2; wrap_exp[2] = 3; wrap_exp[3] = 0; wrap_exp[4] = 1;
        for (int i = 0; i < 5; i++) begin
            step(1, i + 1, i, 0, 0);
            step(0, 0, 0, 0, 0);
            check($sformatf("wrap%0d_cnt_w2", i), int'(issue_cnt2), wrap_exp[i]);
        end
        check("wrap_cnt_w8", int'(issue_cnt), 5);

        // Reset mid-stream: queued commands vanish and nothing partial is emitted.
        step(1, 3, 3, 1, 0);
        step(1, 4, 4, 1, 0);
        step(1, 5, 5, 0, 0);
        do_reset();
        step(0, 0, 0, 0, 0);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_level",     int'(level),     0);
        check("midrst_issue_cnt", int'(issue_cnt), 0);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 3) != 0) ? 1 : 0,
                 int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0) ? 1 : 0,
                 ($urandom_range(0, 29) == 0) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
